// File: rtl/hs_pkg.sv
// Shared definitions for the four-phase request/acknowledge event link.
// Both ends of the link use these, so the transmitter and receiver agree on the counter width.
package hs_pkg;

  typedef enum logic [1:0] {
    HS_IDLE     = 2'd0,
    HS_ACK_HIGH = 2'd1,
    HS_ACK_LOW  = 2'd2
  } hs_state_e;

  localparam int HS_CNT_W = 4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop level synchroniser for an asynchronous handshake wire.
// It uses an asynchronous active-low reset that clears both stages.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/back_handshake.sv
// Receiver of the four-phase request/acknowledge link. It turns completed requests into
// queued events in a saturating counter and presents them through a valid/ready interface.
module back_handshake
  import hs_pkg::*;
#(
  parameter int CNT_W = HS_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic req_in,
  output logic ack_out,
  output logic evt_valid,
  input  logic evt_rdy,
  output logic full,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             req_s;
  hs_state_e        state_q;
  logic             ack_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             inc;
  logic             dec;

  sync_2ff u_req_sync (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    (req_in),
    .q_o    (req_s)
  );

  assign evt_valid = (cnt_q != '0);
  assign full      = (cnt_q == CNT_MAX);
  assign busy      = (state_q != HS_IDLE);
  assign ack_out   = ack_q;

  // Full is taken from the registered count, so a consume on the same edge never frees the slot early.
  assign inc = (state_q == HS_IDLE) && req_s && !full;
  assign dec = evt_valid && evt_rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= HS_IDLE;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= (state_q == HS_ACK_HIGH);
      case (state_q)
        HS_IDLE:     if (inc) state_q <= HS_ACK_HIGH;
        HS_ACK_HIGH: if (!req_s) state_q <= HS_ACK_LOW;
        HS_ACK_LOW:  state_q <= HS_IDLE;
        default:     state_q <= HS_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (dec && !inc) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
